servo_seq_sched: RTL and testbench

- Playback scheduler for the 4-channel servo pose datapath.
- Fetches 64-bit keyframes (four 16-bit pulse widths, ch0 in [15:0] … ch3 in [63:48]) from the keyframe RAM over a req/ack port.
- Presents each keyframe to the pulse timers on a 20 ms frame boundary and holds it for a programmable number of frames.
- Supports one-shot and looped sequences, start/stop control and underrun reporting.

---
 rtl/servo_seq_sched_if.sv | 17 +
 rtl/servo_seq_sched.sv | 203 ++++++++++++++++++++
 tb/tb_servo_seq_sched.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/servo_seq_sched_if.sv
// Keyframe RAM read port between the playback scheduler and the keyframe RAM.
//   mem_rd   : read request, held until mem_ack
//   mem_addr : read address, stable while mem_rd=1
//   mem_ack  : read data valid this cycle
//   mem_data : 64-bit keyframe, ch0 in [15:0] .. ch3 in [63:48]
interface servo_seq_sched_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack;
   logic [63:0]       mem_data;

   // Scheduler side issues requests; RAM side answers them.
   modport master (output mem_rd, output mem_addr, input  mem_ack, input  mem_data);
   modport slave  (input  mem_rd, input  mem_addr, output mem_ack, output mem_data);
endinterface

// File: rtl/servo_seq_sched.sv
// Playback scheduler for the 4-channel servo pose datapath. Fetches keyframes
// from the keyframe RAM, presents each one on a servo frame boundary and holds
// it for hold_frames frames; supports one-shot/looped sequences and stop.
//   clk, rst_n          : clock, synchronous active-low reset
//   start, stop         : sequence control (stop has priority)
//   loop_en             : wrap to base_addr after last_addr
//   base_addr/last_addr : keyframe address range (may wrap through 0)
//   hold_frames         : frames per keyframe (0 behaves as 1)
//   mem                 : keyframe RAM read port (master)
//   pose, pose_load     : pulse widths to the timers and their reload strobe
//   busy, done, underrun: status
module servo_seq_sched #(
   parameter int unsigned ADDR_W      = 8,
   parameter int unsigned TICK_DIV    = 2048,
   parameter int unsigned FRAME_TICKS = 488,
   parameter int unsigned HOLD_W      = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic                stop,
   input  logic                loop_en,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W-1:0]   last_addr,
   input  logic [HOLD_W-1:0]   hold_frames,
   servo_seq_sched_if.master   mem,
   output logic [63:0]         pose,
   output logic                pose_load,
   output logic                busy,
   output logic                done,
   output logic                underrun
);
   localparam int unsigned POSE_W  = 64;
   localparam int unsigned TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned FRAME_W = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;

   typedef enum logic [2:0] {ST_IDLE, ST_FETCH, ST_HOLD, ST_TAIL, ST_DONE} state_e;

   state_e              state_q, state_d;
   logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic [FRAME_W-1:0]  frame_cnt_q, frame_cnt_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d, base_q, base_d, last_q, last_d;
   logic                loop_q, loop_d;
   logic [HOLD_W-1:0]   hold_q, hold_d, hold_cnt_q, hold_cnt_d;
   logic [POSE_W-1:0]   pending_q, pending_d, pose_q, pose_d;
   logic                pending_v_q, pending_v_d, pending_last_q, pending_last_d;
   logic                pose_load_q, pose_load_d, mem_rd_q, mem_rd_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic                busy_q, busy_d, done_q, done_d, underrun_q, underrun_d;
   logic                tick, frame_strobe, start_acc;
   logic [HOLD_W-1:0]   hold_reload;
   logic [ADDR_W-1:0]   ptr_next;

   // Next-state, datapath and timebase
   always_comb begin
      state_d        = state_q;
      ptr_d          = ptr_q;
      base_d         = base_q;
      last_d         = last_q;
      loop_d         = loop_q;
      hold_d         = hold_q;
      hold_cnt_d     = hold_cnt_q;
      pending_d      = pending_q;
      pending_v_d    = pending_v_q;
      pending_last_d = pending_last_q;
      pose_d         = pose_q;
      pose_load_d    = 1'b0;
      done_d         = 1'b0;
      underrun_d     = underrun_q;
      mem_addr_d     = mem_addr_q;
      tick_cnt_d     = '0;
      frame_cnt_d    = '0;

      tick         = busy_q && (tick_cnt_q == TICK_W'(TICK_DIV - 1));
      frame_strobe = tick && (frame_cnt_q == FRAME_W'(FRAME_TICKS - 1));
      start_acc    = start && !stop && ((state_q == ST_IDLE) || (state_q == ST_DONE));
      hold_reload  = (hold_q == '0) ? '0 : hold_q - HOLD_W'(1);
      // Address walk wraps modulo 2^ADDR_W, so base > last runs through 0
      ptr_next     = (ptr_q == last_q) ? base_q : ptr_q + ADDR_W'(1);

      if (stop) begin
         state_d = ST_IDLE;
      end else if (start_acc) begin
         base_d      = base_addr;
         last_d      = last_addr;
         loop_d      = loop_en;
         hold_d      = hold_frames;
         ptr_d       = base_addr;
         hold_cnt_d  = '0;
         pending_v_d = 1'b0;
         underrun_d  = 1'b0;
         state_d     = ST_FETCH;
      end else begin
         unique case (state_q)
            ST_FETCH: begin
               if (mem.mem_ack) begin
                  pending_d      = mem.mem_data;
                  pending_v_d    = 1'b1;
                  pending_last_d = (ptr_q == last_q);
                  ptr_d          = ptr_next;
                  state_d        = ST_HOLD;
               end
               // A strobe coinciding with the ack still sees no keyframe ready
               if (frame_strobe) begin
                  if (hold_cnt_q != '0) hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                  else                  underrun_d = 1'b1;
               end
            end
            ST_HOLD: begin
               if (frame_strobe) begin
                  if (hold_cnt_q != '0) begin
                     hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                  end else begin
                     pose_d      = pending_q;
                     pose_load_d = 1'b1;
                     hold_cnt_d  = hold_reload;
                     pending_v_d = 1'b0;
                     state_d     = (pending_last_q && !loop_q) ? ST_TAIL : ST_FETCH;
                  end
               end
            end
            ST_TAIL: begin
               if (frame_strobe) begin
                  if (hold_cnt_q != '0) begin
                     hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                  end else begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end

      busy_d   = (state_d == ST_FETCH) || (state_d == ST_HOLD) || (state_d == ST_TAIL);
      mem_rd_d = (state_d == ST_FETCH);
      if (mem_rd_d) mem_addr_d = ptr_d;

      // Timebase runs only across busy-to-busy cycles, so start and stop clear it
      if (busy_q && busy_d) begin
         tick_cnt_d  = tick ? '0 : tick_cnt_q + TICK_W'(1);
         frame_cnt_d = frame_cnt_q;
         if (tick) begin
            frame_cnt_d = (frame_cnt_q == FRAME_W'(FRAME_TICKS - 1)) ? '0
                                                                     : frame_cnt_q + FRAME_W'(1);
         end
      end
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         tick_cnt_q     <= '0;
         frame_cnt_q    <= '0;
         ptr_q          <= '0;
         base_q         <= '0;
         last_q         <= '0;
         loop_q         <= 1'b0;
         hold_q         <= '0;
         hold_cnt_q     <= '0;
         pending_q      <= '0;
         pending_v_q    <= 1'b0;
         pending_last_q <= 1'b0;
         pose_q         <= '0;
         pose_load_q    <= 1'b0;
         mem_rd_q       <= 1'b0;
         mem_addr_q     <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         underrun_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         tick_cnt_q     <= tick_cnt_d;
         frame_cnt_q    <= frame_cnt_d;
         ptr_q          <= ptr_d;
         base_q         <= base_d;
         last_q         <= last_d;
         loop_q         <= loop_d;
         hold_q         <= hold_d;
         hold_cnt_q     <= hold_cnt_d;
         pending_q      <= pending_d;
         pending_v_q    <= pending_v_d;
         pending_last_q <= pending_last_d;
         pose_q         <= pose_d;
         pose_load_q    <= pose_load_d;
         mem_rd_q       <= mem_rd_d;
         mem_addr_q     <= mem_addr_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         underrun_q     <= underrun_d;
      end
   end

   assign mem.mem_rd   = mem_rd_q;
   assign mem.mem_addr = mem_addr_q;
   assign pose         = pose_q;
   assign pose_load    = pose_load_q;
   assign busy         = busy_q;
   assign done         = done_q;
   assign underrun     = underrun_q;
endmodule

// File: tb/tb_servo_seq_sched.sv
// Bench for servo_seq_sched with a 20-cycle frame (TICK_DIV=4, FRAME_TICKS=5).
// A frame-number based reference model predicts every output each cycle;
// directed sequences pin the model with hand-computed expectations, then a
// randomized phase exercises start/stop/reset and variable RAM latency.
module tb_servo_seq_sched;
   localparam int unsigned ADDR_W      = 8;
   localparam int unsigned TICK_DIV    = 4;
   localparam int unsigned FRAME_TICKS = 5;
   localparam int unsigned HOLD_W      = 8;
   localparam int          FRAME       = 20;

   logic        clk = 1'b0;
   logic        rst_n, start, stop, loop_en;
   logic [7:0]  base_addr, last_addr, hold_frames;
   logic [63:0] pose;
   logic        pose_load, busy, done, underrun;

   servo_seq_sched_if #(.ADDR_W(ADDR_W)) mif ();

   servo_seq_sched #(
      .ADDR_W(ADDR_W), .TICK_DIV(TICK_DIV), .FRAME_TICKS(FRAME_TICKS), .HOLD_W(HOLD_W)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
      .base_addr(base_addr), .last_addr(last_addr), .hold_frames(hold_frames),
      .mem(mif), .pose(pose), .pose_load(pose_load), .busy(busy), .done(done),
      .underrun(underrun)
   );

   always #5 clk = ~clk;

   logic [63:0] mem [256];
   int n_checks = 0;
   int n_errors = 0;
   int tcur     = 0;
   int ack_delay = 1;
   bit rand_delay = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [63:0] e_pose = '0;
   logic        e_pose_load = 1'b0, e_mem_rd = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_underrun = 1'b0;
   logic [7:0]  e_mem_addr = '0;
   bit          running = 1'b0, m_loop = 1'b0, m_fetching = 1'b0, m_ready = 1'b0;
   logic [7:0]  m_base = '0, m_hold = '0;
   logic [63:0] m_buf = '0;
   int          m_len = 1, m_t = 0, m_fetch_n = 0, m_loaded = 0, m_due = 1;

   function automatic logic [7:0] addr_of(input int n);
      logic [7:0] a;
      a = m_base + 8'(n % m_len);
      return a;
   endfunction

   // Keyframe k is due at frame number m_due; frames fall every FRAME cycles after start
   task automatic model_step();
      bit got;
      int f;
      logic [7:0] d;
      e_pose_load = 1'b0;
      e_done      = 1'b0;
      if (!rst_n) begin
         running = 1'b0; e_pose = '0; e_mem_rd = 1'b0; e_mem_addr = '0;
         e_busy = 1'b0; e_underrun = 1'b0;
      end else if (stop) begin
         running = 1'b0; e_busy = 1'b0; e_mem_rd = 1'b0;
      end else if (!running) begin
         if (start) begin
            m_base = base_addr; d = last_addr - base_addr; m_len = int'(d) + 1;
            m_loop = loop_en; m_hold = hold_frames;
            m_t = 0; m_fetch_n = 0; m_loaded = 0; m_ready = 1'b0; m_due = 1;
            m_fetching = 1'b1; running = 1'b1;
            e_busy = 1'b1; e_underrun = 1'b0; e_mem_rd = 1'b1; e_mem_addr = addr_of(0);
         end
      end else begin
         m_t++;
         got = m_fetching && mif.mem_ack;
         f   = m_t / FRAME;
         if ((m_t % FRAME == 0) && (f == m_due)) begin
            if (!m_loop && (m_loaded == m_len)) begin
               running = 1'b0; e_busy = 1'b0; e_done = 1'b1;
            end else if (m_ready) begin
               e_pose = m_buf; e_pose_load = 1'b1; m_ready = 1'b0; m_loaded++;
               m_due = f + ((m_hold == 0) ? 1 : int'(m_hold));
               if (m_loop || (m_loaded < m_len)) m_fetching = 1'b1;
            end else begin
               e_underrun = 1'b1; m_due = f + 1;
            end
         end
         if (got) begin
            m_buf = mif.mem_data; m_ready = 1'b1; m_fetching = 1'b0; m_fetch_n++;
         end
         e_mem_rd = m_fetching;
         if (m_fetching) e_mem_addr = addr_of(m_fetch_n);
      end
   endtask

   // Per-cycle comparison of every output against the model
   initial begin
      forever begin
         @(posedge clk);
         model_step();
         #1;
         chk("pose",      pose,                 e_pose);
         chk("pose_load", 64'(pose_load),       64'(e_pose_load));
         chk("mem_rd",    64'(mif.mem_rd),      64'(e_mem_rd));
         chk("mem_addr",  64'(mif.mem_addr),    64'(e_mem_addr));
         chk("busy",      64'(busy),            64'(e_busy));
         chk("done",      64'(done),            64'(e_done));
         chk("underrun",  64'(underrun),        64'(e_underrun));
      end
   end

   // ---------------- keyframe RAM responder ----------------
   initial begin
      int wcnt = 0;
      int cur_delay = 1;
      mif.mem_ack  = 1'b0;
      mif.mem_data = '0;
      forever begin
         @(negedge clk);
         if (mif.mem_ack) begin
            mif.mem_ack = 1'b0; wcnt = 0;
         end else if (mif.mem_rd) begin
            if (wcnt == 0) begin
               if (rand_delay)
                  cur_delay = ($urandom_range(0, 3) == 0) ? int'($urandom_range(15, 30))
                                                          : int'($urandom_range(1, 4));
               else
                  cur_delay = ack_delay;
            end
            wcnt++;
            if (wcnt >= cur_delay) begin
               mif.mem_ack = 1'b1; mif.mem_data = mem[mif.mem_addr];
            end
         end else begin
            wcnt = 0;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic do_start(input logic [7:0] b, input logic [7:0] l, input logic [7:0] h,
                           input logic lp);
      base_addr = b; last_addr = l; hold_frames = h; loop_en = lp; start = 1'b1;
      @(negedge clk);
      start = 1'b0; tcur = 0;
   endtask

   task automatic run_to(input int t);
      while (tcur < t) begin
         @(negedge clk);
         tcur++;
      end
   endtask

   task automatic pulse_stop();
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0; tcur++;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
      base_addr = '0; last_addr = '0; hold_frames = '0;
      for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
      repeat (3) @(negedge clk);
      chk("rst_pose", pose, 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_rd",   64'(mif.mem_rd), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // One-shot, inputs scrambled after start
      do_start(8'd0, 8'd2, 8'd2, 1'b0);
      base_addr = 8'd99; last_addr = 8'd7; hold_frames = 8'd9; loop_en = 1'b1;
      chk("os_rd_t0", 64'(mif.mem_rd), 64'd1);
      chk("os_addr_t0", 64'(mif.mem_addr), 64'd0);
      run_to(19);  chk("os_noload_t19", 64'(pose_load), 64'd0);
      run_to(20);  chk("os_load_t20", 64'(pose_load), 64'd1); chk("os_pose_t20", pose, mem[0]);
      run_to(60);  chk("os_load_t60", 64'(pose_load), 64'd1); chk("os_pose_t60", pose, mem[1]);
      run_to(100); chk("os_load_t100", 64'(pose_load), 64'd1); chk("os_pose_t100", pose, mem[2]);
      run_to(139); chk("os_nodone_t139", 64'(done), 64'd0);
      run_to(140); chk("os_done_t140", 64'(done), 64'd1); chk("os_busy_t140", 64'(busy), 64'd0);
      chk("os_rd_t140", 64'(mif.mem_rd), 64'd0);
      run_to(160); chk("os_done_t160", 64'(done), 64'd0); chk("os_unr", 64'(underrun), 64'd0);
      chk("os_pose_kept", pose, mem[2]);

      // Looped sequence
      do_start(8'd3, 8'd4, 8'd1, 1'b1);
      run_to(20);  chk("lp_pose_t20", pose, mem[3]); chk("lp_addr_t20", 64'(mif.mem_addr), 64'd4);
      run_to(40);  chk("lp_pose_t40", pose, mem[4]); chk("lp_addr_t40", 64'(mif.mem_addr), 64'd3);
      run_to(60);  chk("lp_pose_t60", pose, mem[3]);
      run_to(80);  chk("lp_pose_t80", pose, mem[4]); chk("lp_busy_t80", 64'(busy), 64'd1);
      run_to(85);  pulse_stop(); chk("lp_stop_busy", 64'(busy), 64'd0);

      // Underrun: first ack 25 cycles late
      ack_delay = 25;
      do_start(8'd10, 8'd12, 8'd1, 1'b0);
      run_to(20);  chk("ur_unr_t20", 64'(underrun), 64'd1); chk("ur_noload_t20", 64'(pose_load), 64'd0);
      run_to(26);  ack_delay = 1;
      run_to(40);  chk("ur_load_t40", 64'(pose_load), 64'd1); chk("ur_pose_t40", pose, mem[10]);
      run_to(100); chk("ur_done_t100", 64'(done), 64'd1); chk("ur_sticky", 64'(underrun), 64'd1);
      run_to(105);
      do_start(8'd10, 8'd10, 8'd1, 1'b0);
      chk("ur_clr_t0", 64'(underrun), 64'd0);
      run_to(45);

      // Address wrap through 0 with hold=0
      do_start(8'd254, 8'd1, 8'd0, 1'b0);
      chk("wr_addr_t0", 64'(mif.mem_addr), 64'd254);
      run_to(20);  chk("wr_pose_t20", pose, mem[254]); chk("wr_addr_t20", 64'(mif.mem_addr), 64'd255);
      run_to(40);  chk("wr_pose_t40", pose, mem[255]);
      run_to(60);  chk("wr_pose_t60", pose, mem[0]);
      run_to(80);  chk("wr_pose_t80", pose, mem[1]);
      run_to(100); chk("wr_done_t100", 64'(done), 64'd1);
      run_to(105);

      // Stop during a pending read
      ack_delay = 5;
      do_start(8'd20, 8'd22, 8'd1, 1'b0);
      chk("st_rd_t0", 64'(mif.mem_rd), 64'd1);
      pulse_stop();
      chk("st_rd", 64'(mif.mem_rd), 64'd0); chk("st_busy", 64'(busy), 64'd0);
      chk("st_pose", pose, mem[1]);
      run_to(30);
      ack_delay = 1;

      // Start while busy ignored; start+stop leaves IDLE
      do_start(8'd30, 8'd31, 8'd1, 1'b0);
      run_to(10); start = 1'b1; base_addr = 8'd40;
      @(negedge clk); start = 1'b0; tcur++;
      run_to(20); chk("sb_pose_t20", pose, mem[30]);
      run_to(40); chk("sb_pose_t40", pose, mem[31]);
      run_to(45); start = 1'b1; stop = 1'b1;
      @(negedge clk); start = 1'b0; stop = 1'b0; tcur++;
      chk("ss_busy1", 64'(busy), 64'd0);
      run_to(50); start = 1'b1; stop = 1'b1;
      @(negedge clk); start = 1'b0; stop = 1'b0; tcur++;
      chk("ss_busy2", 64'(busy), 64'd0); chk("ss_rd2", 64'(mif.mem_rd), 64'd0);
      run_to(60);

      // Reset mid-HOLD, then replay
      ack_delay = 25;
      do_start(8'd50, 8'd52, 8'd3, 1'b0);
      run_to(26); ack_delay = 1;
      run_to(45); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      chk("rs_pose", pose, 64'd0); chk("rs_busy", 64'(busy), 64'd0);
      chk("rs_rd", 64'(mif.mem_rd), 64'd0); chk("rs_unr", 64'(underrun), 64'd0);
      do_start(8'd50, 8'd52, 8'd3, 1'b0);
      chk("rs_addr_t0", 64'(mif.mem_addr), 64'd50);
      run_to(20); chk("rs_pose_t20", pose, mem[50]);
      pulse_stop();

      // Randomized phase
      rand_delay = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         base_addr   = 8'($urandom);
         last_addr   = base_addr + 8'($urandom_range(0, 4));
         hold_frames = 8'($urandom_range(0, 3));
         loop_en     = ($urandom_range(0, 3) == 0);
         start       = busy ? ($urandom_range(0, 199) == 0) : ($urandom_range(0, 9) == 0);
         stop        = ($urandom_range(0, 299) == 0);
         rst_n       = ($urandom_range(0, 1499) != 0);
         @(negedge clk);
      end
      start = 1'b0; stop = 1'b0; rst_n = 1'b1; rand_delay = 1'b0;
      repeat (5) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
